wb_regfile_unit: RTL and testbench

Clocked writeback stage and architectural register file for the x86-64 pipeline; it replaces the combinational writeback. It accepts one retiring EX/WB record per cycle over a valid/ready handshake. Each record commits up to two register writes plus a stack-pointer adjust, and signals store commit. It also keeps a per-register busy scoreboard for hazard detection and serves the decode read ports. A simulation-end record moves the unit into a halted state.

---
 rtl/wb_pkg.sv | 46 ++++
 rtl/wb_scoreboard.sv | 30 +++
 rtl/wb_regfile_unit.sv | 159 +++++++++++++++
 tb/tb_wb_regfile_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : wb_pkg                                                 |
// | Description : Shared types and default constants for the writeback  |
// |               stage / register file.                                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package wb_pkg;

  localparam int NREGS_DEF  = 16;
  localparam int XLEN_DEF   = 64;
  localparam int SP_IDX_DEF = 4;
  localparam int IDXW_DEF   = $clog2(NREGS_DEF);

  // Stack-pointer adjust encoding; 2'b11 is reserved and behaves as none
  typedef enum logic [1:0] {
    SP_NONE = 2'b00,
    SP_INC  = 2'b01,
    SP_DEC  = 2'b10
  } sp_adj_e;

  typedef enum logic [0:0] {
    WB_RUN  = 1'b0,
    WB_HALT = 1'b1
  } wb_state_e;

  // One retiring EX/WB record at the default configuration widths
  typedef struct packed {
    logic                we0;
    logic [IDXW_DEF-1:0] dst0;
    logic [XLEN_DEF-1:0] data0;
    logic                we1;
    logic [IDXW_DEF-1:0] dst1;
    logic [XLEN_DEF-1:0] data1;
    logic [1:0]          sp_adj;
    logic                store;
    logic                sim_end;
  } wb_record_t;

  // True when the adjust code actually moves SP (reserved code does not)
  function automatic logic sp_adj_active(input logic [1:0] adj);
    return (adj == SP_INC) || (adj == SP_DEC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_scoreboard                                          |
// | Description : Per-register busy flags. Issue sets, writeback clears, |
// |               and a set wins over a clear of the same bit.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int NREGS = NREGS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREGS-1:0] set_mask,
  input  logic [NREGS-1:0] clr_mask,
  output logic [NREGS-1:0] busy
);

  // Busy flags: clear first, then OR in the sets so a set always wins
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_regfile_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_regfile_unit                                        |
// | Description : Clocked writeback stage and architectural register     |
// |               file: two writes plus SP adjust per record, busy       |
// |               scoreboard, decode read ports, RUN/HALT control.       |
// |               Optional macro WB_BYPASS_EN forwards the current       |
// |               cycle's writes and clears to the read ports.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module wb_regfile_unit
  import wb_pkg::*;
#(
  parameter int              NREGS    = NREGS_DEF,
  parameter int              XLEN     = XLEN_DEF,
  parameter int              NRD      = 3,
  parameter int              SP_IDX   = SP_IDX_DEF,
  parameter int              SP_STEP  = 8,
  parameter logic [XLEN-1:0] SP_RESET = '0,
  parameter int              IDXW     = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic                  wb_we0,
  input  logic [IDXW-1:0]       wb_dst0,
  input  logic [XLEN-1:0]       wb_data0,
  input  logic                  wb_we1,
  input  logic [IDXW-1:0]       wb_dst1,
  input  logic [XLEN-1:0]       wb_data1,
  input  logic [1:0]            wb_sp_adj,
  input  logic                  wb_store,
  input  logic                  wb_sim_end,
  input  logic                  iss_valid,
  input  logic [NREGS-1:0]      iss_mask,
  input  logic [NRD*IDXW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  output logic [NREGS-1:0]      busy,
  output logic                  store_commit,
  output logic                  sim_done,
  output logic [NREGS*XLEN-1:0] regs_flat
);

  localparam logic [XLEN-1:0] SP_STEP_X = XLEN'(SP_STEP);

  wb_state_e        state;
  wb_state_e        state_nxt;
  logic             accept;
  logic             sp_active;
  logic [XLEN-1:0]  regs     [NREGS];
  logic [XLEN-1:0]  regs_nxt [NREGS];
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  assign accept    = wb_valid & wb_ready;
  assign sp_active = sp_adj_active(wb_sp_adj);
  assign set_mask  = iss_valid ? iss_mask : '0;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WB_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a sim-end record halts the unit until reset
  always_comb begin
    state_nxt = state;
    if (state == WB_RUN && accept && wb_sim_end) begin
      state_nxt = WB_HALT;
    end
  end

  // FSM outputs: ready and done come from state only, never from wb_valid
  always_comb begin
    wb_ready = (state == WB_RUN);
    sim_done = (state == WB_HALT);
  end

  // Next register values and scoreboard clears; later assignments win,
  // giving dst1 over dst0 over SP adjust. SP adjust uses the pre-edge SP.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NREGS; i++) begin
      regs_nxt[i] = regs[i];
      if (accept && sp_active && i == SP_IDX) begin
        regs_nxt[i] = (wb_sp_adj == SP_INC) ? regs[i] + SP_STEP_X
                                            : regs[i] - SP_STEP_X;
        clr_mask[i] = 1'b1;
      end
      if (accept && wb_we0 && wb_dst0 == IDXW'(i)) begin
        regs_nxt[i] = wb_data0;
        clr_mask[i] = 1'b1;
      end
      if (accept && wb_we1 && wb_dst1 == IDXW'(i)) begin
        regs_nxt[i] = wb_data1;
        clr_mask[i] = 1'b1;
      end
    end
  end

  // Architectural register array
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reset) begin
        regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end else begin
        regs[i] <= regs_nxt[i];
      end
    end
  end

  // Store commit pulse, one cycle after an accepted store record
  always_ff @(posedge clk) begin
    if (reset) begin
      store_commit <= 1'b0;
    end else begin
      store_commit <= accept & wb_store;
    end
  end

  wb_scoreboard #(
    .NREGS(NREGS)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_mask(set_mask),
    .clr_mask(clr_mask),
    .busy    (busy)
  );

`ifdef WB_BYPASS_EN
  // Busy as it will be after this edge, so reads see same-cycle clears
  logic [NREGS-1:0] busy_fwd;
  assign busy_fwd = (busy & ~clr_mask) | set_mask;
`endif

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [IDXW-1:0] addr;
    assign addr = rd_addr[k*IDXW +: IDXW];
`ifdef WB_BYPASS_EN
    assign rd_data[k*XLEN +: XLEN] = regs_nxt[addr];
    assign rd_busy[k]              = busy_fwd[addr];
`else
    assign rd_data[k*XLEN +: XLEN] = regs[addr];
    assign rd_busy[k]              = busy[addr];
`endif
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_flat
    assign regs_flat[i*XLEN +: XLEN] = regs[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_wb_regfile_unit                                     |
// | Description : Directed self-checking bench for wb_regfile_unit with  |
// |               an expected-value queue and a register model.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_wb_regfile_unit;

  logic          clk;
  logic          reset;
  logic          wb_valid;
  logic          wb_ready;
  logic          wb_we0;
  logic [3:0]    wb_dst0;
  logic [63:0]   wb_data0;
  logic          wb_we1;
  logic [3:0]    wb_dst1;
  logic [63:0]   wb_data1;
  logic [1:0]    wb_sp_adj;
  logic          wb_store;
  logic          wb_sim_end;
  logic          iss_valid;
  logic [15:0]   iss_mask;
  logic [11:0]   rd_addr;
  logic [191:0]  rd_data;
  logic [2:0]    rd_busy;
  logic [15:0]   busy;
  logic          store_commit;
  logic          sim_done;
  logic [1023:0] regs_flat;

  logic [63:0] m [16];
  logic [63:0] exp_q [$];
  string       tag_q [$];
  int          compared   = 0;
  int          mismatched = 0;

  wb_regfile_unit #(
    .SP_RESET(64'h7fff_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_we0      (wb_we0),
    .wb_dst0     (wb_dst0),
    .wb_data0    (wb_data0),
    .wb_we1      (wb_we1),
    .wb_dst1     (wb_dst1),
    .wb_data1    (wb_data1),
    .wb_sp_adj   (wb_sp_adj),
    .wb_store    (wb_store),
    .wb_sim_end  (wb_sim_end),
    .iss_valid   (iss_valid),
    .iss_mask    (iss_mask),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .busy        (busy),
    .store_commit(store_commit),
    .sim_done    (sim_done),
    .regs_flat   (regs_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        mismatched++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic push_regs();
    for (int i = 0; i < 16; i++) push($sformatf("reg%0d", i), m[i]);
  endtask

  task automatic pop_regs();
    for (int i = 0; i < 16; i++) pop(regs_flat[i*64 +: 64]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = 64'h0;
    m[4] = 64'h7fff_0000;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid   = 1'b0;
    wb_we0     = 1'b0;
    wb_dst0    = 4'd0;
    wb_data0   = 64'h0;
    wb_we1     = 1'b0;
    wb_dst1    = 4'd0;
    wb_data1   = 64'h0;
    wb_sp_adj  = 2'b00;
    wb_store   = 1'b0;
    wb_sim_end = 1'b0;
    iss_valid  = 1'b0;
    iss_mask   = 16'h0;
  endtask

  task automatic rec(input logic we0, input logic [3:0] d0, input logic [63:0] v0,
                     input logic we1, input logic [3:0] d1, input logic [63:0] v1,
                     input logic [1:0] adj, input logic st, input logic se);
    wb_valid   = 1'b1;
    wb_we0     = we0;
    wb_dst0    = d0;
    wb_data0   = v0;
    wb_we1     = we1;
    wb_dst1    = d1;
    wb_data1   = v1;
    wb_sp_adj  = adj;
    wb_store   = st;
    wb_sim_end = se;
  endtask

  initial begin
    reset   = 1'b1;
    rd_addr = 12'h0;
    idle();
    model_reset();

    // Reset state
    cyc();
    cyc();
    push_regs();
    push("busy_rst", 64'h0);
    push("ready_rst", 64'h1);
    push("done_rst", 64'h0);
    push("stc_rst", 64'h0);
    pop_regs();
    pop(64'(busy));
    pop(64'(wb_ready));
    pop(64'(sim_done));
    pop(64'(store_commit));
    reset = 1'b0;

    // Single write to reg3, read on port 0
    rd_addr = {4'd0, 4'd0, 4'd3};
    rec(1'b1, 4'd3, 64'h1234, 1'b0, 4'd0, 64'h0, 2'b00, 1'b0, 1'b0);
    m[3] = 64'h1234;
`ifdef WB_BYPASS_EN
    push("rd3_same", 64'h1234);
`else
    push("rd3_same", 64'h0);
`endif
    #1;
    pop(rd_data[63:0]);
    push("rd3_next", 64'h1234);
    cyc();
    pop(rd_data[63:0]);
    idle();

    // Dual write on one edge
    rec(1'b1, 4'd0, 64'hA, 1'b1, 4'd2, 64'hB, 2'b00, 1'b0, 1'b0);
    m[0] = 64'hA;
    m[2] = 64'hB;
    push("reg0_mul", 64'hA);
    push("reg2_mul", 64'hB);
    cyc();
    pop(regs_flat[63:0]);
    pop(regs_flat[191:128]);

    // Same-index writes: dst1 wins
    rd_addr = {4'd0, 4'd5, 4'd3};
    rec(1'b1, 4'd5, 64'h1, 1'b1, 4'd5, 64'h2, 2'b00, 1'b0, 1'b0);
    m[5] = 64'h2;
    push("rd5_dst1_wins", 64'h2);
    cyc();
    pop(rd_data[127:64]);
    idle();

    // PUSH from SP=0x1000 with store commit pulse
    rec(1'b1, 4'd4, 64'h1000, 1'b0, 4'd0, 64'h0, 2'b00, 1'b0, 1'b0);
    m[4] = 64'h1000;
    cyc();
    rec(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 64'h0, 2'b10, 1'b1, 1'b0);
    m[4] = m[4] - 64'd8;
    push("sp_push", 64'h0ff8);
    push("stc_pulse", 64'h1);
    cyc();
    pop(regs_flat[319:256]);
    pop(64'(store_commit));
    idle();
    push("stc_drop", 64'h0);
    cyc();
    pop(64'(store_commit));

    // POP into SP keeps the loaded value
    rec(1'b1, 4'd4, 64'h500, 1'b0, 4'd0, 64'h0, 2'b01, 1'b0, 1'b0);
    m[4] = 64'h500;
    push("sp_pop", 64'h500);
    cyc();
    pop(regs_flat[319:256]);

    // Plain increment, then decrement wrapping below zero
    rec(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 64'h0, 2'b01, 1'b0, 1'b0);
    m[4] = m[4] + 64'd8;
    push("sp_inc", 64'h508);
    cyc();
    pop(regs_flat[319:256]);
    rec(1'b1, 4'd4, 64'h0, 1'b0, 4'd0, 64'h0, 2'b00, 1'b0, 1'b0);
    cyc();
    rec(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 64'h0, 2'b10, 1'b0, 1'b0);
    m[4] = 64'h0 - 64'd8;
    push("sp_wrap", 64'hffff_ffff_ffff_fff8);
    cyc();
    pop(regs_flat[319:256]);
    idle();

    // Scoreboard: set, set-wins over clear, clear
    rd_addr   = {4'd7, 4'd5, 4'd3};
    iss_valid = 1'b1;
    iss_mask  = 16'h0080;
    push("busy_set7", 64'h0080);
    push("rdbusy_set7", 64'h4);
    cyc();
    pop(64'(busy));
    pop(64'(rd_busy));
    rec(1'b1, 4'd7, 64'h77, 1'b0, 4'd0, 64'h0, 2'b00, 1'b0, 1'b0);
    m[7] = 64'h77;
    push("busy_setwins", 64'h0080);
    cyc();
    pop(64'(busy));
    iss_valid = 1'b0;
    iss_mask  = 16'h0;
    rec(1'b1, 4'd7, 64'h78, 1'b0, 4'd0, 64'h0, 2'b00, 1'b0, 1'b0);
    m[7] = 64'h78;
    push("busy_clr7", 64'h0);
    cyc();
    pop(64'(busy));
    idle();
    iss_valid = 1'b1;
    iss_mask  = 16'h0210;
    push("busy_set4_9", 64'h0210);
    cyc();
    pop(64'(busy));
    idle();
    rec(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 64'h0, 2'b01, 1'b0, 1'b0);
    m[4] = m[4] + 64'd8;
    push("busy_spclr", 64'h0200);
    cyc();
    pop(64'(busy));
    idle();
    push_regs();
    pop_regs();

    // Sim-end record commits and halts
    rec(1'b1, 4'd1, 64'hdead, 1'b0, 4'd0, 64'h0, 2'b00, 1'b0, 1'b1);
    m[1] = 64'hdead;
    push("done_halt", 64'h1);
    push("ready_halt", 64'h0);
    push("reg1_end", 64'hdead);
    cyc();
    idle();
    pop(64'(sim_done));
    pop(64'(wb_ready));
    pop(regs_flat[127:64]);

    // Offered record while halted is ignored
    rec(1'b1, 4'd1, 64'hbeef, 1'b0, 4'd0, 64'h0, 2'b10, 1'b1, 1'b0);
    push("stc_halt", 64'h0);
    cyc();
    pop(64'(store_commit));
    cyc();
    idle();
    push_regs();
    push("done_hold", 64'h1);
    pop_regs();
    pop(64'(sim_done));

    // Reset out of HALT
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    model_reset();
    push("ready_rerst", 64'h1);
    push("done_rerst", 64'h0);
    push("busy_rerst", 64'h0);
    pop(64'(wb_ready));
    pop(64'(sim_done));
    pop(64'(busy));
    push_regs();
    pop_regs();

    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
